// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - descriptor stream between a program source and the encoder/loader
// master drives symbolic descriptors, slave returns op_ready.
interface instr_encoder_loader_if;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_class;
  logic [2:0]  op_funct3;
  logic        op_f7b5;
  logic [4:0]  op_rd;
  logic [4:0]  op_rs1;
  logic [4:0]  op_rs2;
  logic [20:0] op_imm;
  logic        op_last;

  modport master (
    output op_valid, op_class, op_funct3, op_f7b5, op_rd, op_rs1, op_rs2, op_imm, op_last,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_class, op_funct3, op_f7b5, op_rd, op_rs1, op_rs2, op_imm, op_last,
    output op_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes symbolic descriptors to RV32I words and writes them into IMEM
// Optional IMM_RANGE_CHECK_EN: out-of-range immediates are replaced by NOP and flagged in err_o.
module instr_encoder_loader #(
  parameter int ADDR_W    = 32,
  parameter int MAX_INSTR = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  instr_encoder_loader_if.slave op_if,
  output logic                  imem_we_o,
  output logic [ADDR_W-1:0]     imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic [6:0]            count_o,
  output logic                  done_o,
  output logic                  trunc_o,
  output logic                  err_o
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [6:0]  MAX_CNT = 7'(MAX_INSTR);

  localparam logic [2:0] CLS_LW   = 3'd0;
  localparam logic [2:0] CLS_SW   = 3'd1;
  localparam logic [2:0] CLS_R    = 3'd2;
  localparam logic [2:0] CLS_BEQ  = 3'd3;
  localparam logic [2:0] CLS_JAL  = 3'd4;
  localparam logic [2:0] CLS_JALR = 3'd5;
  localparam logic [2:0] CLS_IMM  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [6:0]          count_q, count_d;
  logic                trunc_q, trunc_d;
  logic                err_q, err_d;
  logic                last_q, last_d;

  logic [20:0] imm;
  logic [2:0]  cls;
  logic [2:0]  f3;
  logic        f7b5;
  logic [4:0]  rd, rs1, rs2;
  logic        is_shift;
  logic [31:0] enc_raw;
  logic        cls_bad;
  logic [31:0] enc_word;
  logic        enc_bad;

  assign imm      = op_if.op_imm;
  assign cls      = op_if.op_class;
  assign f3       = op_if.op_funct3;
  assign f7b5     = op_if.op_f7b5;
  assign rd       = op_if.op_rd;
  assign rs1      = op_if.op_rs1;
  assign rs2      = op_if.op_rs2;
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Pure field packing; funct3 is forced by class except for R and IMM.
  always_comb begin
    enc_raw = NOP;
    cls_bad = 1'b0;
    case (cls)
      CLS_LW:   enc_raw = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      CLS_SW:   enc_raw = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      CLS_R:    enc_raw = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
      CLS_BEQ:  enc_raw = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      CLS_JAL:  enc_raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      CLS_JALR: enc_raw = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      CLS_IMM: begin
        if (is_shift) begin
          enc_raw = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, f3, rd, 7'b0010011};
        end else begin
          enc_raw = {imm[11:0], rs1, f3, rd, 7'b0010011};
        end
      end
      default: begin
        enc_raw = NOP;
        cls_bad = 1'b1;
      end
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic fits_i;
  logic fits_b;
  logic shamt_ok;
  logic range_bad;

  // Signed fit: every bit above the field's sign bit must replicate it.
  assign fits_i   = (imm[20:11] == {10{imm[11]}});
  assign fits_b   = (imm[20:12] == {9{imm[12]}});
  assign shamt_ok = (imm[20:5] == 16'd0);

  always_comb begin
    range_bad = 1'b0;
    case (cls)
      CLS_LW, CLS_SW, CLS_JALR: range_bad = !fits_i;
      CLS_IMM:                  range_bad = is_shift ? !shamt_ok : !fits_i;
      CLS_BEQ:                  range_bad = !fits_b || imm[0];
      CLS_JAL:                  range_bad = imm[0];
      default:                  range_bad = 1'b0;
    endcase
  end

  assign enc_bad  = cls_bad || range_bad;
  assign enc_word = enc_bad ? NOP : enc_raw;
`else
  logic unused_imm0;

  assign unused_imm0 = imm[0];
  assign enc_bad     = cls_bad;
  assign enc_word    = enc_raw;
`endif

  assign op_if.op_ready = (state_q == S_ACCEPT);
  assign imem_we_o      = (state_q == S_WRITE);
  assign done_o         = (state_q == S_DONE);
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign count_o        = count_q;
  assign trunc_o        = trunc_q;
  assign err_o          = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      trunc_q <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    trunc_d = trunc_q;
    err_d   = err_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ACCEPT;
          addr_d  = base_addr_i;
          count_d = '0;
          trunc_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (op_if.op_valid) begin
          wdata_d = enc_word;
          last_d  = op_if.op_last;
          err_d   = err_q || enc_bad;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(4);
        count_d = count_q + 7'd1;
        // The cap ends the session even when the source never flagged a last descriptor.
        if (last_q || (count_q + 7'd1 == MAX_CNT)) begin
          state_d = S_DONE;
          trunc_d = !last_q;
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - randomized and directed checks of instr_encoder_loader against a reference model
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1;
  logic [31:0] base0, base1;
  logic        we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [6:0]  count0, count1;
  logic        done0, done1, trunc0, trunc1, err0, err1;

  instr_encoder_loader_if if0 ();
  instr_encoder_loader_if if1 ();

  instr_encoder_loader #(.ADDR_W(32), .MAX_INSTR(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .base_addr_i(base0), .op_if(if0),
    .imem_we_o(we0), .imem_addr_o(addr0), .imem_wdata_o(wdata0), .count_o(count0),
    .done_o(done0), .trunc_o(trunc0), .err_o(err0)
  );

  instr_encoder_loader #(.ADDR_W(32), .MAX_INSTR(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .base_addr_i(base1), .op_if(if1),
    .imem_we_o(we1), .imem_addr_o(addr1), .imem_wdata_o(wdata1), .count_o(count1),
    .done_o(done1), .trunc_o(trunc1), .err_o(err1)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_addr;
  int          exp_count;
  bit          exp_err;

  // Reference encoder: fields placed by integer arithmetic on the sign-extended immediate.
  function automatic void model_encode(input int cls, input int f3, input int f7, input int rd,
                                       input int rs1, input int rs2, input logic [20:0] imm,
                                       output logic [31:0] w, output bit bad);
    int s;
    bit range_bad;
    s = int'({11'd0, imm});
    if (imm[20]) s = s - 2097152;
    w = 32'h13;
    bad = 1'b0;
    range_bad = 1'b0;
    case (cls)
      0: begin
        w = ((s & 4095) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
        range_bad = (s < -2048) || (s > 2047);
      end
      1: begin
        w = (((s >>> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((s & 31) << 7) | 'h23;
        range_bad = (s < -2048) || (s > 2047);
      end
      2: w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
      3: begin
        w = (((s >>> 12) & 1) << 31) | (((s >>> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
          | (((s >>> 1) & 15) << 8) | (((s >>> 11) & 1) << 7) | 'h63;
        range_bad = (s < -4096) || (s > 4095) || ((s & 1) != 0);
      end
      4: begin
        w = (((s >>> 20) & 1) << 31) | (((s >>> 1) & 1023) << 21) | (((s >>> 11) & 1) << 20)
          | (((s >>> 12) & 255) << 12) | (rd << 7) | 'h6F;
        range_bad = ((s & 1) != 0);
      end
      5: begin
        w = ((s & 4095) << 20) | (rs1 << 15) | (rd << 7) | 'h67;
        range_bad = (s < -2048) || (s > 2047);
      end
      6: begin
        if (f3 == 1 || f3 == 5) begin
          w = (f7 << 30) | ((s & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
          range_bad = (s < 0) || (s > 31);
        end else begin
          w = ((s & 4095) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
          range_bad = (s < -2048) || (s > 2047);
        end
      end
      default: bad = 1'b1;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    if (range_bad) begin
      w = 32'h13;
      bad = 1'b1;
    end
`else
    range_bad = 1'b0;
`endif
  endfunction

  task automatic start_session(input logic [31:0] base);
    @(posedge clk); #1;
    vectors++;
    if (done0 !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse_width: done=%b, want 0", done0);
    end
    start0 = 1'b1;
    base0  = base;
    @(posedge clk); #1;
    start0 = 1'b0;
    exp_addr  = base;
    exp_count = 0;
    exp_err   = 1'b0;
  endtask

  // Drives one descriptor into dut0 and checks its write; golden overrides the model word when use_golden.
  task automatic send_op(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [20:0] imm, input logic last,
                         input bit use_golden, input logic [31:0] golden, input string tag);
    logic [31:0] w;
    bit bad;
    int n;
    model_encode(int'(cls), int'(f3), int'(f7), int'(rd), int'(rs1), int'(rs2), imm, w, bad);
    if (use_golden) w = golden;
    if0.op_valid = 1'b1; if0.op_class = cls; if0.op_funct3 = f3; if0.op_f7b5 = f7;
    if0.op_rd = rd; if0.op_rs1 = rs1; if0.op_rs2 = rs2; if0.op_imm = imm; if0.op_last = last;
    n = 0;
    while (if0.op_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL %s handshake: op_ready=%b after %0d cycles, want 1", tag, if0.op_ready, n);
      if0.op_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if0.op_valid = 1'b0;
    vectors++;
    if (we0 !== 1'b1 || addr0 !== exp_addr || wdata0 !== w) begin
      miscompares++;
      $display("FAIL %s write: we=%b addr=%h wdata=%h, want we=1 addr=%h wdata=%h",
               tag, we0, addr0, wdata0, exp_addr, w);
    end
    exp_addr  = exp_addr + 32'd4;
    exp_count = exp_count + 1;
    exp_err   = exp_err | bad;
    @(posedge clk); #1;
    vectors++;
    if (last) begin
      if (done0 !== 1'b1 || count0 !== 7'(exp_count) || err0 !== exp_err || trunc0 !== 1'b0
          || we0 !== 1'b0 || if0.op_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s session_end: done=%b count=%0d err=%b trunc=%b we=%b ready=%b, want 1 %0d %b 0 0 0",
                 tag, done0, count0, err0, trunc0, we0, if0.op_ready, exp_count, exp_err);
      end
    end else begin
      if (we0 !== 1'b0 || if0.op_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL %s next_accept: we=%b ready=%b, want we=0 ready=1", tag, we0, if0.op_ready);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (if0.op_ready !== 1'b0 || we0 !== 1'b0 || addr0 !== 32'd0 || wdata0 !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_bus: ready=%b we=%b addr=%h wdata=%h, want all 0", if0.op_ready, we0, addr0, wdata0);
    end
    vectors++;
    if (count0 !== 7'd0 || done0 !== 1'b0 || trunc0 !== 1'b0 || err0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: count=%0d done=%b trunc=%b err=%b, want all 0", count0, done0, trunc0, err0);
    end
  endtask

  task automatic test_directed;
    start_session(32'h0);
    send_op(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1, 1'b1, 32'h0050_0093, "addi_x1_5");
    start_session(32'h0);
    send_op(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 32'h0020_81B3, "add");
    send_op(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 32'h4020_81B3, "sub");
    start_session(32'h100);
    send_op(3'd1, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'd8, 1'b0, 1'b1, 32'h0020_A423, "sw");
    send_op(3'd0, 3'd0, 1'b0, 5'd5, 5'd1, 5'd0, 21'h1F_FFFC, 1'b0, 1'b1, 32'hFFC0_A283, "lw");
    send_op(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'd8, 1'b0, 1'b1, 32'h0020_8463, "beq");
    send_op(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd16, 1'b0, 1'b1, 32'h0100_00EF, "jal");
    send_op(3'd7, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 21'd0, 1'b0, 1'b1, 32'h0000_0013, "illegal");
`ifdef IMM_RANGE_CHECK_EN
    send_op(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd2048, 1'b1, 1'b1, 32'h0000_0013, "addi_2048");
`else
    send_op(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd2048, 1'b1, 1'b1, 32'h8000_0093, "addi_2048");
`endif
    start_session(32'h200);
    send_op(3'd2, 3'd5, 1'b1, 5'd7, 5'd8, 5'd9, 21'd0, 1'b1, 1'b0, 32'h0, "sra_fresh_err");
  endtask

  task automatic test_random;
    logic [31:0] bases [4];
    bases[0] = $urandom & 32'hFFFF_FFFC;
    bases[1] = 32'hFFFF_FFF8;
    bases[2] = $urandom & 32'h0000_FFFC;
    bases[3] = $urandom & 32'hFFFF_FFFC;
    for (int s = 0; s < 4; s++) begin
      int nops;
      nops = $urandom_range(3, 8);
      start_session(bases[s]);
      for (int k = 0; k < nops; k++) begin
        logic [2:0] cls;
        logic [20:0] imm;
        logic [31:0] r;
        cls = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        r = $urandom;
        if ($urandom_range(0, 1) == 0) imm = 21'($signed($urandom_range(0, 127)) - 64);
        else imm = r[20:0];
        send_op(cls, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm, (k == nops - 1),
                1'b0, 32'h0, "random");
      end
    end
  endtask

  task automatic test_ignore;
    @(posedge clk); #1;
    if0.op_valid = 1'b1;
    if0.op_class = 3'd6; if0.op_funct3 = 3'd0; if0.op_imm = 21'd1; if0.op_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (we0 !== 1'b0 || if0.op_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_valid_ignored: we=%b ready=%b, want 0 0", we0, if0.op_ready);
      end
    end
    if0.op_valid = 1'b0;
    start_session(32'h0000_4000);
    start0 = 1'b1;
    base0  = 32'h0000_8000;
    @(posedge clk); #1;
    start0 = 1'b0;
    send_op(3'd5, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 21'd12, 1'b1, 1'b0, 32'h0, "start_in_accept");
  endtask

  task automatic test_trunc;
    logic [31:0] w;
    bit bad;
    int n;
    @(posedge clk); #1;
    start1 = 1'b1;
    base1  = 32'h40;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if1.op_valid = 1'b1; if1.op_class = 3'd6; if1.op_funct3 = 3'd0; if1.op_f7b5 = 1'b0;
      if1.op_rd = 5'(k + 1); if1.op_rs1 = 5'd0; if1.op_rs2 = 5'd0; if1.op_imm = 21'(k + 3); if1.op_last = 1'b0;
      model_encode(6, 0, 0, k + 1, 0, 0, 21'(k + 3), w, bad);
      n = 0;
      while (if1.op_ready !== 1'b1 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      @(posedge clk); #1;
      if1.op_valid = 1'b0;
      vectors++;
      if (we1 !== 1'b1 || addr1 !== 32'h40 + 32'(4 * k) || wdata1 !== w) begin
        miscompares++;
        $display("FAIL trunc_write%0d: we=%b addr=%h wdata=%h, want 1 %h %h", k, we1, addr1, wdata1,
                 32'h40 + 32'(4 * k), w);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (done1 !== 1'b1 || trunc1 !== 1'b1 || count1 !== 7'd2 || err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL trunc_end: done=%b trunc=%b count=%0d err=%b, want 1 1 2 0", done1, trunc1, count1, err1);
    end
    if1.op_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (we1 !== 1'b0 || trunc1 !== 1'b1) begin
        miscompares++;
        $display("FAIL trunc_third_op: we=%b trunc=%b, want 0 1", we1, trunc1);
      end
    end
    if1.op_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    start_session(32'h0000_0800);
    if0.op_valid = 1'b1; if0.op_class = 3'd6; if0.op_funct3 = 3'd0; if0.op_f7b5 = 1'b0;
    if0.op_rd = 5'd4; if0.op_rs1 = 5'd4; if0.op_rs2 = 5'd0; if0.op_imm = 21'd77; if0.op_last = 1'b0;
    n = 0;
    while (if0.op_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    if0.op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (we0 !== 1'b0 || addr0 !== 32'd0 || wdata0 !== 32'd0 || count0 !== 7'd0
        || done0 !== 1'b0 || trunc0 !== 1'b0 || err0 !== 1'b0 || if0.op_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_write: we=%b addr=%h wdata=%h count=%0d done=%b trunc=%b err=%b ready=%b, want all 0",
               we0, addr0, wdata0, count0, done0, trunc0, err0, if0.op_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (we0 !== 1'b0 || count0 !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_mid_after: we=%b count=%0d, want 0 0", we0, count0);
    end
    start_session(32'h0000_0010);
    send_op(3'd0, 3'd0, 1'b0, 5'd9, 5'd3, 5'd0, 21'd20, 1'b1, 1'b0, 32'h0, "after_reset");
  endtask

  initial begin
    start0 = 1'b0; start1 = 1'b0; base0 = '0; base1 = '0;
    if0.op_valid = 1'b0; if0.op_class = '0; if0.op_funct3 = '0; if0.op_f7b5 = 1'b0;
    if0.op_rd = '0; if0.op_rs1 = '0; if0.op_rs2 = '0; if0.op_imm = '0; if0.op_last = 1'b0;
    if1.op_valid = 1'b0; if1.op_class = '0; if1.op_funct3 = '0; if1.op_f7b5 = 1'b0;
    if1.op_rd = '0; if1.op_rs1 = '0; if1.op_rs2 = '0; if1.op_imm = '0; if1.op_last = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_ignore();
    test_trunc();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
